// File: rtl/uart_image_sender.sv
// uart_image_sender
//
// Uploads a memory image over an 8N1 UART line. On start it sends a 12-byte
// header (MAGIC, size_bytes, dst_addr, each MSB byte first), then fetches the
// image one 32-bit word at a time and sends each word MSB byte first. A short
// final word sends only its upper size_bytes[1:0] bytes. Bytes within the
// header and within a word leave no idle clocks between them.
//
// Optional feature macro: UART_IMAGE_SENDER_ACK_EN
//   defined   : after the last byte, wait for an ack byte (8'hAA = done,
//               8'hFF = error) or ACK_TIMEOUT clocks (= error).
//   undefined : go straight to DONE after the last byte; rx_* are unused.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin upload (level, sampled in IDLE)
//   src_addr                image source byte address
//   dst_addr                target load address (sent in header)
//   size_bytes              image length in bytes
//   mem_addr/mem_req        word read request, held until mem_ready
//   mem_rdata/mem_ready     read data and its valid strobe
//   uart_tx                 serial line, idle high
//   rx_data/rx_valid        ack byte from an external receiver
//   busy/done/error         status; done/error hold until start drops
//   bytes_sent              image data bytes whose stop bit has completed
module uart_image_sender #(
   parameter int          CLOCK_FREQ  = 40000000,
   parameter int          BAUD_RATE   = 115200,
   parameter logic [31:0] MAGIC       = 32'hB007C0DE,
   parameter int          ACK_TIMEOUT = 4000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [31:0] size_bytes,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        uart_tx,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] bytes_sent
);

   localparam int          BAUD_DIV  = CLOCK_FREQ / BAUD_RATE;
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   typedef enum logic [2:0] {IDLE, HDR, FETCH, DATA, ACK_WAIT, DONE, ERROR} state_t;

`ifdef UART_IMAGE_SENDER_ACK_EN
   localparam state_t      END_STATE = ACK_WAIT;
   localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT - 1);
   logic [31:0] ack_cnt_r;
`else
   localparam state_t END_STATE = DONE;
   logic unused_s;
   assign unused_s = ^{rx_data, rx_valid, 32'(ACK_TIMEOUT)};
`endif

   state_t      state_r, next_state_s;
   logic        load_s;
   logic [7:0]  load_byte_s;
   logic        byte_end_s;

   logic        uart_tx_r, tx_busy_r;
   logic [8:0]  shift_r;
   logic [3:0]  bit_cnt_r;
   logic [15:0] baud_cnt_r;

   logic [31:0] size_r, dst_r, fetch_addr_r, word_r, bytes_sent_r, mem_addr_r;
   logic [3:0]  hdr_idx_r;
   logic [1:0]  byte_idx_r;
   logic        busy_r, done_r, error_r, mem_req_r;

   // Byte idx (0 = most significant) of a word
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   // Header byte idx 0..11: MAGIC, size, destination
   function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [31:0] sz,
                                           input logic [31:0] dst);
      logic [31:0] w;
      case (idx[3:2])
         2'd0:    w = MAGIC;
         2'd1:    w = sz;
         default: w = dst;
      endcase
      return word_byte(w, idx[1:0]);
   endfunction

   // Last clock of a stop bit
   assign byte_end_s = tx_busy_r && (bit_cnt_r == 4'd9) && (baud_cnt_r == BAUD_LAST);

   // Next-state logic; load_s starts a new frame on the same edge the previous one ends
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      load_byte_s  = 8'h00;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = HDR;
               load_s       = 1'b1;
               load_byte_s  = MAGIC[31:24];
            end else begin
               next_state_s = IDLE;
            end
         end
         HDR: begin
            if (byte_end_s) begin
               if (hdr_idx_r == 4'd11) begin
                  if (size_r != 32'd0) begin
                     next_state_s = FETCH;
                  end else begin
                     next_state_s = END_STATE;
                  end
               end else begin
                  load_s      = 1'b1;
                  load_byte_s = hdr_byte(hdr_idx_r + 4'd1, size_r, dst_r);
               end
            end else begin
               next_state_s = HDR;
            end
         end
         FETCH: begin
            if (mem_req_r && mem_ready) begin
               next_state_s = DATA;
               load_s       = 1'b1;
               load_byte_s  = mem_rdata[31:24];
            end else begin
               next_state_s = FETCH;
            end
         end
         DATA: begin
            if (byte_end_s) begin
               if (bytes_sent_r + 32'd1 == size_r) begin
                  next_state_s = END_STATE;
               end else if (byte_idx_r == 2'd3) begin
                  next_state_s = FETCH;
               end else begin
                  load_s      = 1'b1;
                  load_byte_s = word_byte(word_r, byte_idx_r + 2'd1);
               end
            end else begin
               next_state_s = DATA;
            end
         end
         ACK_WAIT: begin
`ifdef UART_IMAGE_SENDER_ACK_EN
            if (rx_valid && (rx_data == 8'hAA)) begin
               next_state_s = DONE;
            end else if (rx_valid && (rx_data == 8'hFF)) begin
               next_state_s = ERROR;
            end else if (ack_cnt_r == ACK_LAST) begin
               next_state_s = ERROR;
            end else begin
               next_state_s = ACK_WAIT;
            end
`else
            next_state_s = DONE;
`endif
         end
         DONE, ERROR: begin
            if (!start) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = state_r;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= next_state_s;
   end

   // Registered status and memory request outputs, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         mem_req_r  <= 1'b0;
         mem_addr_r <= 32'd0;
      end else begin
         busy_r    <= (next_state_s == HDR) || (next_state_s == FETCH) ||
                      (next_state_s == DATA) || (next_state_s == ACK_WAIT);
         done_r    <= (next_state_s == DONE);
         error_r   <= (next_state_s == ERROR);
         mem_req_r <= (next_state_s == FETCH);
         if (next_state_s == FETCH) mem_addr_r <= fetch_addr_r;
      end
   end

   // Bit serializer: start bit, 8 data bits LSB first, stop bit, BAUD_DIV clocks each
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_tx_r  <= 1'b1;
         tx_busy_r  <= 1'b0;
         shift_r    <= 9'h1FF;
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= 16'd0;
      end else if (load_s) begin
         uart_tx_r  <= 1'b0;
         tx_busy_r  <= 1'b1;
         shift_r    <= {1'b1, load_byte_s};
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= 16'd0;
      end else if (tx_busy_r) begin
         if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= 16'd0;
            if (bit_cnt_r == 4'd9) begin
               tx_busy_r <= 1'b0;
               uart_tx_r <= 1'b1;
            end else begin
               bit_cnt_r <= bit_cnt_r + 4'd1;
               uart_tx_r <= shift_r[0];
               shift_r   <= {1'b1, shift_r[8:1]};
            end
         end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
         end
      end else begin
         uart_tx_r <= 1'b1;
      end
   end

   // Job bookkeeping: latched parameters, byte indices, fetch address, data byte count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_r       <= 32'd0;
         dst_r        <= 32'd0;
         fetch_addr_r <= 32'd0;
         word_r       <= 32'd0;
         bytes_sent_r <= 32'd0;
         hdr_idx_r    <= 4'd0;
         byte_idx_r   <= 2'd0;
      end else begin
         case (state_r)
            IDLE: if (start) begin
               size_r       <= size_bytes;
               dst_r        <= dst_addr;
               fetch_addr_r <= src_addr;
               bytes_sent_r <= 32'd0;
               hdr_idx_r    <= 4'd0;
            end
            HDR: if (byte_end_s) hdr_idx_r <= hdr_idx_r + 4'd1;
            FETCH: if (mem_req_r && mem_ready) begin
               word_r       <= mem_rdata;
               byte_idx_r   <= 2'd0;
               fetch_addr_r <= fetch_addr_r + 32'd4;
            end
            DATA: if (byte_end_s) begin
               bytes_sent_r <= bytes_sent_r + 32'd1;
               byte_idx_r   <= byte_idx_r + 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef UART_IMAGE_SENDER_ACK_EN
   // Ack timeout counter, zero on the first ACK_WAIT clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  ack_cnt_r <= 32'd0;
      else if (state_r == ACK_WAIT) ack_cnt_r <= ack_cnt_r + 32'd1;
      else                         ack_cnt_r <= 32'd0;
   end
`endif

   assign uart_tx    = uart_tx_r;
   assign mem_req    = mem_req_r;
   assign mem_addr   = mem_addr_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign error      = error_r;
   assign bytes_sent = bytes_sent_r;

endmodule

// File: tb/tb_uart_image_sender.sv
// Scoreboard bench for uart_image_sender (BAUD_DIV = 4, 40 clocks per byte).
// Stimulus pushes expected UART bytes and memory addresses into queues; a UART
// decoder and a memory model pop and compare independently.
module tb_uart_image_sender;

   localparam logic [31:0] MAGIC = 32'hB007C0DE;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_addr = 32'd0, dst_addr = 32'd0, size_bytes = 32'd0;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ready = 1'b0;
   logic        uart_tx;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        busy, done, error;
   logic [31:0] bytes_sent;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0;
   int bytes_seen = 0;
   int last_stop_cyc = 0;
   int start_cyc = 0;
   int mem_wait = 0;
   logic [31:0] mem_base = 32'd0;
   logic [7:0]  exp_q[$];
   logic [31:0] addr_q[$];
   logic [7:0]  data_tbl [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [7:0]  mon_byte;
   bit          mon_ok;

   uart_image_sender #(
      .CLOCK_FREQ (1000000),
      .BAUD_RATE  (250000),
      .MAGIC      (MAGIC),
      .ACK_TIMEOUT(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .size_bytes(size_bytes),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .uart_tx(uart_tx), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .done(done), .error(error), .bytes_sent(bytes_sent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] idx);
      if (idx == 32'd0)      return 32'h11223344;
      else if (idx == 32'd1) return 32'h55667788;
      else                   return 32'h0;
   endfunction

   // UART decoder: samples mid-bit on falling clock edges, compares with exp_q
   initial begin : uart_mon
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && uart_tx === 1'b0) begin
            mon_ok = 1'b1;
            repeat (2) @(negedge clk);
            if (rst_n !== 1'b1) mon_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               if (rst_n !== 1'b1) mon_ok = 1'b0;
               mon_byte[i] = uart_tx;
            end
            repeat (4) @(negedge clk);
            if (rst_n !== 1'b1) mon_ok = 1'b0;
            if (mon_ok) begin
               check("stop_bit", {31'd0, uart_tx}, 32'd1);
               if (exp_q.size() == 0) begin
                  check("unexpected_uart_byte", {24'd0, mon_byte}, 32'hFFFF_FFFF);
               end else begin
                  check("uart_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
               end
               last_stop_cyc = cyc;
               bytes_seen++;
            end
         end
      end
   end

   // Memory model: mem_ready 3 clocks after mem_req rises, address checked against addr_q
   initial begin : mem_model
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1 && mem_ready === 1'b0) begin
            mem_wait++;
            if (mem_wait == 3) begin
               if (addr_q.size() == 0) check("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
               else                    check("mem_addr", mem_addr, addr_q.pop_front());
               mem_rdata = mem_word((mem_addr - mem_base) >> 2);
               mem_ready = 1'b1;
            end
         end else begin
            mem_ready = 1'b0;
            mem_wait  = 0;
            mem_rdata = 32'hDEAD_BEEF;
         end
      end
   end

   task automatic push_word(input logic [31:0] w);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Queue expectations, pulse (or hold) start, wait until every byte is decoded
   task automatic launch(input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] size, input bit hold);
      int target;
      mem_base = src;
      push_word(MAGIC);
      push_word(size);
      push_word(dst);
      for (int i = 0; i < int'(size); i++) exp_q.push_back(data_tbl[i]);
      for (int w = 0; w < int'((size + 32'd3) >> 2); w++) addr_q.push_back(src + 32'(4 * w));
      target = bytes_seen + 12 + int'(size);
      @(negedge clk);
      src_addr = src; dst_addr = dst; size_bytes = size;
      start = 1'b1;
      start_cyc = cyc + 1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int k = 0; k < 2000 && bytes_seen < target; k++) @(negedge clk);
      if (bytes_seen < target) check("frame_wait_expired", bytes_seen, target);
   endtask

   // First falling-edge cycle at which done (or error) reads 1
   task automatic wait_flag(input bit want_err, output int seen);
      seen = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if ((want_err ? error : done) === 1'b1) begin
            seen = cyc;
            break;
         end
      end
      if (seen < 0) check("flag_wait_expired", 32'd0, 32'd1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, actual running required finished");
      $fatal(1);
   end

   initial begin : stim
      int c;
      int lows;
      repeat (3) @(negedge clk);
      check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_bytes_sent", bytes_sent, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      send_rx(8'hAA);
      check("idle_rx_no_done", {31'd0, done}, 32'd0);
      check("idle_rx_no_busy", {31'd0, busy}, 32'd0);

`ifdef UART_IMAGE_SENDER_ACK_EN
      // Zero-size upload, acknowledged
      launch(32'h0, 32'h100, 32'd0, 1'b0);
      check("hdr_480_clocks", last_stop_cyc - start_cyc, 32'd478);
      repeat (3) @(negedge clk);
      check("ack_wait_busy", {31'd0, busy}, 32'd1);
      check("ack_wait_no_done", {31'd0, done}, 32'd0);
      send_rx(8'hAA);
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_bytes_sent", bytes_sent, 32'd0);
      check("zero_done_not_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("done_clears", {31'd0, done}, 32'd0);

      // Two full words, source wraps past 2^32, start held throughout
      launch(32'hFFFF_FFFC, 32'h2000_0000, 32'd8, 1'b1);
      repeat (2) @(negedge clk);
      send_rx(8'hAA);
      check("data_done", {31'd0, done}, 32'd1);
      check("data_bytes_sent", bytes_sent, 32'd8);
      repeat (4) @(negedge clk);
      check("done_held", {31'd0, done}, 32'd1);
      start = 1'b0;
      @(negedge clk);
      check("done_drops", {31'd0, done}, 32'd0);

      // Partial final word, junk ack then error ack
      launch(32'h1000, 32'h8000_0000, 32'd6, 1'b0);
      send_rx(8'h12);
      check("junk_ack_no_error", {31'd0, error}, 32'd0);
      check("junk_ack_busy", {31'd0, busy}, 32'd1);
      send_rx(8'hFF);
      check("nak_error", {31'd0, error}, 32'd1);
      check("partial_bytes_sent", bytes_sent, 32'd6);
      check("nak_not_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("error_clears", {31'd0, error}, 32'd0);

      // Ack timeout
      launch(32'h0, 32'h300, 32'd0, 1'b0);
      wait_flag(1'b1, c);
      check("timeout_100_clocks", c - last_stop_cyc, 32'd102);
      check("timeout_no_done", {31'd0, done}, 32'd0);
`else
      // One word, rx strobing an error byte throughout (must be ignored)
      rx_data  = 8'hFF;
      rx_valid = 1'b1;
      launch(32'h1000, 32'h4000, 32'd4, 1'b0);
      wait_flag(1'b0, c);
      rx_valid = 1'b0;
      check("done_after_stop", c - last_stop_cyc, 32'd2);
      check("noack_no_error", {31'd0, error}, 32'd0);
      check("noack_bytes_sent", bytes_sent, 32'd4);

      // Zero-size upload
      launch(32'h0, 32'h100, 32'd0, 1'b0);
      check("hdr_480_clocks", last_stop_cyc - start_cyc, 32'd478);
      wait_flag(1'b0, c);
      check("zero_done_after_stop", c - last_stop_cyc, 32'd2);
      check("zero_bytes_sent", bytes_sent, 32'd0);

      // Two full words, source wraps past 2^32, start held throughout
      launch(32'hFFFF_FFFC, 32'h2000_0000, 32'd8, 1'b1);
      wait_flag(1'b0, c);
      check("data_bytes_sent", bytes_sent, 32'd8);
      repeat (4) @(negedge clk);
      check("done_held", {31'd0, done}, 32'd1);
      start = 1'b0;
      @(negedge clk);
      check("done_drops", {31'd0, done}, 32'd0);

      // Partial final word
      launch(32'h1000, 32'h8000_0000, 32'd6, 1'b0);
      wait_flag(1'b0, c);
      check("partial_done_after_stop", c - last_stop_cyc, 32'd2);
      check("partial_bytes_sent", bytes_sent, 32'd6);
`endif

      // Reset during data bit 3 of header byte 2
      exp_q.push_back(8'hB0);
      exp_q.push_back(8'h07);
      @(negedge clk);
      src_addr = 32'h1000; dst_addr = 32'h0; size_bytes = 32'd4;
      start = 1'b1;
      start_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < start_cyc + 97) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_error", {31'd0, error}, 32'd0);
      check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      check("midrst_bytes_sent", bytes_sent, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      check("line_idle_after_reset", lows, 32'd0);
      check("idle_after_reset", {31'd0, busy}, 32'd0);
      check("uart_queue_drained", exp_q.size(), 32'd0);
      check("addr_queue_drained", addr_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
